// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes and FSM states.
package lsu_pkg;

  // Access size encoding, taken from funct3[1:0]
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // One memory transaction at a time: accept, request, wait, present result
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU: builds the store byte mask and the
// lane-shifted store data, and turns the raw 8-byte read word into a
// truncated, sign- or zero-extended 64-bit load result.
// The offset is forced down to the access alignment, so no access ever
// crosses the 8-byte lane.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [2:0]        i_off,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rsp_data,
  output logic [7:0]        o_wmask,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  // Truncate the lane-shifted read word to the access size and extend it
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                               input logic [1:0] size,
                                               input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic               s;
    b = raw[7:0];
    h = raw[15:0];
    w = raw[31:0];
    case (size)
      SZ_B: begin
        s = b[7] & ~uns;
        extend = {{(DATA_W-8){s}}, b};
      end
      SZ_H: begin
        s = h[15] & ~uns;
        extend = {{(DATA_W-16){s}}, h};
      end
      SZ_W: begin
        s = w[31] & ~uns;
        extend = {{(DATA_W-32){s}}, w};
      end
      default: extend = raw;
    endcase
  endfunction

  logic [2:0] w_off;
  logic [5:0] w_shamt;
  logic [7:0] w_mask_base;

  // Offset masking, mask generation and lane shifting
  always_comb begin
    w_off       = i_off;
    w_mask_base = 8'h01;
    case (i_size)
      SZ_B: begin
        w_off       = i_off;
        w_mask_base = 8'h01;
      end
      SZ_H: begin
        w_off       = {i_off[2:1], 1'b0};
        w_mask_base = 8'h03;
      end
      SZ_W: begin
        w_off       = {i_off[2], 2'b00};
        w_mask_base = 8'h0F;
      end
      default: begin
        w_off       = 3'd0;
        w_mask_base = 8'hFF;
      end
    endcase
    w_shamt = {w_off, 3'b000};
    o_wmask = w_mask_base << w_off;
    o_wdata = i_wdata << w_shamt;
    o_rdata = extend(i_rsp_data >> w_shamt, i_size, i_unsigned);
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between execute and memory. Latches one access from
// execute, issues a single valid/ready memory request, waits for the
// read data or write ack, and presents the formatted load result (0 for
// stores) until writeback takes it.
// Optional: define LSU_MISALIGN_CHECK_EN to add out_misalign; misaligned
// accesses then skip memory and complete with out_misalign=1.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic              out_misalign
`endif
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic              r_wen;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [7:0]        w_wmask;
  logic [DATA_W-1:0] w_wdata_sh;
  logic [DATA_W-1:0] w_rdata_ext;
  logic              w_in_misalign;

`ifdef LSU_MISALIGN_CHECK_EN
  logic r_misalign;

  // True when the low address bits are not a multiple of the access size
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = |off[1:0];
      SZ_D:    misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  endfunction

  assign w_in_misalign = misaligned(in_funct3[1:0], in_addr[2:0]);
  assign out_misalign  = r_misalign;
`else
  assign w_in_misalign = 1'b0;
`endif

  lsu_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .i_size    (r_funct3[1:0]),
    .i_unsigned(r_funct3[2]),
    .i_off     (r_addr[2:0]),
    .i_wdata   (r_wdata),
    .i_rsp_data(mem_rsp_data),
    .o_wmask   (w_wmask),
    .o_wdata   (w_wdata_sh),
    .o_rdata   (w_rdata_ext)
  );

  assign in_ready      = (r_state == ST_IDLE);
  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_req_addr  = {r_addr[ADDR_W-1:3], 3'b000};
  assign mem_req_wen   = r_wen;
  assign mem_req_wdata = w_wdata_sh;
  assign mem_req_wmask = r_wen ? w_wmask : 8'h00;
  assign out_valid     = (r_state == ST_RESP);
  assign out_rdata     = r_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; the response is only looked at in WAIT
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)      w_state_nxt = w_in_misalign ? ST_RESP : ST_REQ;
      ST_REQ:  if (mem_req_ready) w_state_nxt = ST_WAIT;
      ST_WAIT: if (mem_rsp_valid) w_state_nxt = ST_RESP;
      ST_RESP: if (out_ready)     w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Latched request fields and the held result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen    <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_wen    <= in_wen;
            r_funct3 <= in_funct3;
            r_addr   <= in_addr;
            r_wdata  <= in_wdata;
            r_rdata  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_misalign <= w_in_misalign;
`endif
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) r_rdata <= r_wen ? '0 : w_rdata_ext;
        end
        ST_RESP: begin
`ifdef LSU_MISALIGN_CHECK_EN
          if (out_ready) r_misalign <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized accesses with
// random memory and writeback backpressure, against a byte-level model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen;
  logic [2:0]  in_funct3;
  logic [63:0] in_addr, in_wdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        out_valid, out_ready;
  logic [63:0] out_rdata;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        out_misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wen       (in_wen),
    .in_funct3    (in_funct3),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_req_wen  (mem_req_wen),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rdata    (out_rdata)
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    .out_misalign (out_misalign)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: byte view of the 8-byte word
  function automatic int m_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int m_off(input logic [2:0] f3, input logic [63:0] addr);
    int n;
    int off;
    n   = m_bytes(f3);
    off = int'(addr[2:0]);
    return off - (off % n);
  endfunction

  function automatic logic m_misalign(input logic [2:0] f3, input logic [63:0] addr);
    return (int'(addr[2:0]) % m_bytes(f3)) != 0;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] addr,
                                         input logic [63:0] rsp);
    logic [63:0] v;
    int n;
    int off;
    n   = m_bytes(f3);
    off = m_off(f3, addr);
    v   = 64'd0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = rsp[(off+i)*8 +: 8];
    if (!f3[2] && v[n*8-1])
      for (int i = n*8; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] m_mask(input logic [2:0] f3, input logic [63:0] addr);
    logic [7:0] m;
    int n;
    int off;
    n   = m_bytes(f3);
    off = m_off(f3, addr);
    m   = 8'h00;
    for (int i = 0; i < n; i++) m[off+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [2:0] f3, input logic [63:0] addr,
                                          input logic [63:0] wd);
    return wd << (m_off(f3, addr) * 8);
  endfunction

  // One complete access with the given memory/writeback stall counts
  task automatic access(input logic wen, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [63:0] rsp,
                        input int dreq, input int drsp, input int dout,
                        output logic [63:0] o_rd, output logic [7:0] o_m,
                        output logic [63:0] o_wd);
    logic [63:0] e_rd;
    logic [7:0]  e_m;
    logic [63:0] e_wd;
    logic        mis;
    e_rd = wen ? 64'd0 : m_load(f3, addr, rsp);
    e_m  = wen ? m_mask(f3, addr) : 8'h00;
    e_wd = m_wdata(f3, addr, wd);
    mis  = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = m_misalign(f3, addr);
    if (mis) e_rd = 64'd0;
`endif
    chk("idle_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_wen    = wen;
    in_funct3 = f3;
    in_addr   = addr;
    in_wdata  = wd;
    @(negedge clk);
    in_valid = 1'b0;
    in_addr  = {$urandom, $urandom};
    in_wdata = {$urandom, $urandom};
    in_funct3 = 3'($urandom);
    in_wen   = 1'($urandom);
    o_m  = mem_req_wmask;
    o_wd = mem_req_wdata;
    if (!mis) begin
      for (int i = 0; i <= dreq; i++) begin
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_req_addr, {addr[63:3], 3'b000});
        chk("req_wen", mem_req_wen, wen);
        chk("req_wmask", mem_req_wmask, e_m);
        if (wen) chk("req_wdata", mem_req_wdata, e_wd);
        chk("req_in_ready", in_ready, 0);
        chk("req_out_valid", out_valid, 0);
        if (i == dreq) mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
      end
      for (int i = 0; i <= drsp; i++) begin
        chk("wait_req_valid", mem_req_valid, 0);
        chk("wait_out_valid", out_valid, 0);
        chk("wait_in_ready", in_ready, 0);
        if (i == drsp) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = rsp;
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = {$urandom, $urandom};
      end
    end
    o_rd = out_rdata;
    for (int i = 0; i <= dout; i++) begin
      chk("resp_out_valid", out_valid, 1);
      chk("resp_rdata", out_rdata, e_rd);
      chk("resp_in_ready", in_ready, 0);
      chk("resp_req_valid", mem_req_valid, 0);
`ifdef LSU_MISALIGN_CHECK_EN
      chk("resp_misalign", out_misalign, mis);
`endif
      if (i == dout) out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk("done_in_ready", in_ready, 1);
    chk("done_out_valid", out_valid, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("done_misalign", out_misalign, 0);
`endif
  endtask

  initial begin
    logic [63:0] rd, wd;
    logic [7:0]  m;
    logic        wen;
    logic [2:0]  f3;
    rst = 1'b1;
    in_valid = 1'b0; in_wen = 1'b0; in_funct3 = 3'd0; in_addr = '0; in_wdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rdata", out_rdata, 0);

    // Stray response while idle must be ignored
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1234;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("stray_rsp_out_valid", out_valid, 0);

    // LB sign extension, minimum latency
    access(1'b0, 3'b000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 0, rd, m, wd);
    chk("lb_rdata", rd, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_wmask", {56'd0, m}, 64'h0);

    // LHU / LWU zero extension
    access(1'b0, 3'b101, 64'h8000_0004, 64'd0, 64'hDEAD_BEEF_1234_5678, 0, 0, 0, rd, m, wd);
    chk("lhu_rdata", rd, 64'h0000_0000_0000_BEEF);
    access(1'b0, 3'b110, 64'h8000_0004, 64'd0, 64'hDEAD_BEEF_1234_5678, 0, 0, 0, rd, m, wd);
    chk("lwu_rdata", rd, 64'h0000_0000_DEAD_BEEF);

    // SB / SW lanes
    access(1'b1, 3'b000, 64'h8000_0005, 64'hAB, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, rd, m, wd);
    chk("sb_wmask", {56'd0, m}, 64'h20);
    chk("sb_lane5", {56'd0, wd[47:40]}, 64'hAB);
    chk("sb_rdata", rd, 64'h0);
    access(1'b1, 3'b010, 64'h8000_0004, 64'h1122_3344, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, rd, m, wd);
    chk("sw_wmask", {56'd0, m}, 64'hF0);
    chk("sw_wdata", wd, 64'h1122_3344_0000_0000);
    chk("sw_rdata", rd, 64'h0);

    // Backpressure on every handshake
    access(1'b0, 3'b011, 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 4, 3, 2, rd, m, wd);
    chk("ld_bp_rdata", rd, 64'h0123_4567_89AB_CDEF);

    // Reset while waiting for the response, then a late response
    in_valid = 1'b1; in_wen = 1'b0; in_funct3 = 3'b011; in_addr = 64'h8000_0020;
    @(negedge clk);
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("wait_before_rst", mem_req_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("rst_wait_in_ready", in_ready, 1);
    chk("rst_wait_out_valid", out_valid, 0);
    chk("rst_wait_rdata", out_rdata, 0);
    access(1'b0, 3'b011, 64'h8000_0028, 64'd0, 64'h5555_6666_7777_8888, 0, 1, 0, rd, m, wd);
    chk("ld_after_rst", rd, 64'h5555_6666_7777_8888);

`ifdef LSU_MISALIGN_CHECK_EN
    access(1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'h0, 0, 0, 0, rd, m, wd);
    chk("mis_lw_rdata", rd, 64'h0);
`endif

    // Randomized accesses
    for (int t = 0; t < 200; t++) begin
      wen = 1'($urandom);
      f3  = wen ? {1'b0, 2'($urandom)} : 3'($urandom);
      access(wen, f3, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), rd, m, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit in the execute→memory path of the RV64 NPC core, directly downstream of the ALU.
- Consumes the ALU-computed effective address and the store data, and runs one memory transaction over a valid/ready request/response bus.
- Returns load data byte-aligned and sign- or zero-extended to 64 bits.
- Handles one access at a time; this is a multi-cycle FSM.

Parameters:
- ADDR_W, 64, width of the effective address and the memory address.
- DATA_W, 64, memory bus data width (fixed 8 byte lanes).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  access request from execute
- in_ready  out  1  LSU can accept (IDLE only)
- in_wen  in  1  1=store, 0=load
- in_funct3  in  3  RISC-V funct3 (size/sign)
- in_addr  in  64  effective address (ALU result)
- in_wdata  in  64  store data (rs2)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  64  in_addr with [2:0] forced to 0
- mem_req_wen  out  1  write request
- mem_req_wdata  out  64  lane-shifted store data
- mem_req_wmask  out  8  byte-enable mask; 0 for loads
- mem_rsp_valid  in  1  response / write-ack valid
- mem_rsp_data  in  64  raw 8-byte-aligned read data
- out_valid  out  1  result available
- out_ready  in  1  writeback consumes result
- out_rdata  out  64  extended load result; 0 for stores

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset: state=IDLE; mem_req_valid=0, out_valid=0, out_rdata=0, in_ready=1; all latched request fields cleared.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: in_ready=1. On in_valid, latch wen, funct3, addr, wdata and go to REQ.
- REQ: mem_req_valid=1; address, data and mask are held stable. On mem_req_ready go to WAIT; otherwise stay in REQ.
- WAIT: on mem_rsp_valid, capture the formatted result into out_rdata and go to RESP. Stores also wait for mem_rsp_valid, which acts as the write ack, and set out_rdata=0.
- RESP: out_valid=1 and out_rdata is held. On out_ready go to IDLE; in_ready rises the next cycle, so there is no same-cycle re-accept.
- mem_rsp_valid outside WAIT is ignored. The response is never accepted in the same cycle as mem_req_ready.
- Minimum latency: accept at cycle T, request at T+1 with ready, response at T+2, out_valid at T+3.
- Size comes from funct3[1:0]: 00=B, 01=H, 10=W, 11=D. For loads, funct3[2]=1 selects zero-extension.
- Load funct3 111 and store funct3[2]=1 are treated as size funct3[1:0], unsigned; the decoder does not issue them.
- off = addr[2:0]. Without misalignment checking, off is masked to the access alignment: H ignores bit0, W ignores [1:0], D uses off=0. No access crosses an 8-byte lane.
- Store mask: B=8'h01<<off, H=8'h03<<off, W=8'h0F<<off, D=8'hFF. wdata is shifted left by off*8.
- Load: raw = mem_rsp_data >> off*8, then truncate to size and extend to 64 bits.
- Reset mid-operation: return to IDLE immediately; any outstanding response is dropped, because WAIT has been left.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: adds output out_misalign (1 bit, reset 0).
- In IDLE, an access with off not aligned to its size goes directly to RESP without a memory request. out_misalign=1, out_rdata=0; out_misalign clears on leaving RESP.
- Undefined: no out_misalign port; the off masking above applies.

Decomposition:
- Package lsu_pkg: size localparams (SZ_B=2'b00, SZ_H, SZ_W, SZ_D) and FSM state localparams (ST_IDLE=2'd0, ST_REQ, ST_WAIT, ST_RESP).
- Sub-module lsu_align: purely combinational; (size, unsigned, off, wdata, rsp_data) → (wmask, shifted wdata, extended rdata). Instantiated once in lsu.

Test Plan:
- LB sign: addr=0x8000_0003, rsp=0x0000_0000_8000_0000, memory ready immediately → mem_req_addr=0x8000_0000, wmask=0, out_rdata=0xFFFF_FFFF_FFFF_FF80 at T+3.
- LHU/LWU zero-extend: addr=0x8000_0004, rsp=0xDEAD_BEEF_1234_5678 → LHU gives 0x0000_0000_0000_BEEF; LWU gives 0x0000_0000_DEAD_BEEF.
- SB/SW lanes: SB addr=0x8000_0005, wdata=0xAB → wmask=8'h20, wdata lane5=0xAB. SW addr=0x8000_0004, wdata=0x1122_3344 → wmask=8'hF0, wdata=0x1122_3344_0000_0000. out_rdata=0 after ack.
- Backpressure: mem_req_ready low 4 cycles, rsp delayed 3 cycles, out_ready low 2 cycles → request fields and out_rdata stable throughout; in_ready=0 until the cycle after the out handshake.
- Reset in WAIT, then a late mem_rsp_valid → stays IDLE, out_valid=0; the next LD returns its own data.
- With LSU_MISALIGN_CHECK_EN: LW at addr=0x8000_0002 → no mem_req_valid, out_valid next cycle with out_misalign=1.
